// File: rtl/lc3_regfile_cc.sv
// LC-3 register file R0-R7 with NZP condition codes, branch evaluation and a
// per-register outstanding-load scoreboard; reads are combinational with write-through bypass.
module lc3_regfile_cc #(
   parameter int          DATA_W  = 16,
   parameter int          NREG    = 8,
   parameter int          ADDR_W  = 3,
   parameter logic [2:0]  NZP_RST = 3'b010
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] sr1_addr,
   input  logic [ADDR_W-1:0] sr2_addr,
   output logic [DATA_W-1:0] sr1_data,
   output logic [DATA_W-1:0] sr2_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              cc_en,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic              sr1_busy,
   output logic              sr2_busy,
   input  logic [2:0]        br_nzp,
   output logic              br_taken,
   output logic [2:0]        nzp
);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [NREG-1:0]   busy_q;
   logic [NREG-1:0]   busy_d;
   logic [2:0]        nzp_q;
   logic [2:0]        nzp_d;

   logic wr_act;
   logic sr1_wr_hit;
   logic sr2_wr_hit;
   logic sr1_iss_hit;
   logic sr2_iss_hit;

   function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] v);
      logic n;
      logic z;
      n = v[DATA_W-1];
      z = (v == '0);
      return {n, z, ~n & ~z};
   endfunction

   // Bypass paths are suppressed while rst is held so all outputs show the reset state.
   assign wr_act      = wr_en & ~rst;
   assign sr1_wr_hit  = wr_act & (wr_addr == sr1_addr);
   assign sr2_wr_hit  = wr_act & (wr_addr == sr2_addr);
   assign sr1_iss_hit = issue_en & (issue_addr == sr1_addr);
   assign sr2_iss_hit = issue_en & (issue_addr == sr2_addr);

   assign sr1_data = sr1_wr_hit ? wr_data : regs_q[sr1_addr];
   assign sr2_data = sr2_wr_hit ? wr_data : regs_q[sr2_addr];
   assign sr1_busy = (sr1_wr_hit & ~sr1_iss_hit) ? 1'b0 : busy_q[sr1_addr];
   assign sr2_busy = (sr2_wr_hit & ~sr2_iss_hit) ? 1'b0 : busy_q[sr2_addr];

   // Branch sees only the registered flags, never a same-cycle cc update.
   assign nzp      = nzp_q;
   assign br_taken = |(br_nzp & nzp_q);

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      nzp_d  = nzp_q;
      if (wr_en) begin
         regs_d[wr_addr] = wr_data;
         busy_d[wr_addr] = 1'b0;
      end
      // Issue is applied last so a new load to the register being written stays busy.
      if (issue_en) begin
         busy_d[issue_addr] = 1'b1;
      end
      if (cc_en) begin
         nzp_d = cc_of(wr_data);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
         nzp_q  <= NZP_RST;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         nzp_q  <= nzp_d;
      end
   end

endmodule

// File: tb/tb_lc3_regfile_cc.sv
// Bench for lc3_regfile_cc: directed feature scenarios followed by a long
// randomized run against an array-based reference model.
module tb_lc3_regfile_cc;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  sr1_addr, sr2_addr, wr_addr, issue_addr, br_nzp;
   logic [15:0] sr1_data, sr2_data, wr_data;
   logic        wr_en, cc_en, issue_en;
   logic        sr1_busy, sr2_busy, br_taken;
   logic [2:0]  nzp;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_reg [8];
   logic [7:0]  m_busy;
   logic [2:0]  m_nzp;

   always #5 clk = ~clk;

   lc3_regfile_cc dut (
      .clk(clk), .rst(rst),
      .sr1_addr(sr1_addr), .sr2_addr(sr2_addr),
      .sr1_data(sr1_data), .sr2_data(sr2_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cc_en(cc_en), .issue_en(issue_en), .issue_addr(issue_addr),
      .sr1_busy(sr1_busy), .sr2_busy(sr2_busy),
      .br_nzp(br_nzp), .br_taken(br_taken), .nzp(nzp)
   );

   function automatic logic [2:0] flags_of(input logic [15:0] v);
      if ($signed(v) < 0) return 3'b100;
      if (v == 16'd0) return 3'b010;
      return 3'b001;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = 16'd0;
      m_busy = 8'd0;
      m_nzp  = 3'b010;
   endtask

   // One rising edge; the model absorbs the inputs that were present at the edge.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (cc_en) m_nzp = flags_of(wr_data);
         if (wr_en) begin
            m_reg[wr_addr]  = wr_data;
            m_busy[wr_addr] = 1'b0;
         end
         if (issue_en) m_busy[issue_addr] = 1'b1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 0; cc_en = 0; issue_en = 0;
      wr_addr = 0; wr_data = 0; issue_addr = 0; br_nzp = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      wr_en = 1; wr_addr = 3; wr_data = 16'h1234; cc_en = 1;
      issue_en = 1; issue_addr = 6;
      tick();
      idle_inputs();
      sr1_addr = 3; sr2_addr = 6;
      #1;
      checks++;
      if (sr1_data !== 16'h1234) begin errors++; $display("FAIL reset_pre_r3 got %h want %h", sr1_data, 16'h1234); end
      checks++;
      if (sr2_busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy got %b want 1", sr2_busy); end
      #2;
      rst = 1;
      model_reset();
      #1;
      checks++;
      if (sr1_data !== 16'h0000) begin errors++; $display("FAIL reset_r3 got %h want 0000", sr1_data); end
      checks++;
      if (nzp !== 3'b010) begin errors++; $display("FAIL reset_nzp got %b want 010", nzp); end
      checks++;
      if (sr2_busy !== 1'b0 || sr1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b%b want 00", sr1_busy, sr2_busy); end
      // Activity presented while in reset must be dropped.
      wr_en = 1; wr_addr = 3; wr_data = 16'h8001; cc_en = 1; issue_en = 1; issue_addr = 3;
      #1;
      checks++;
      if (sr1_data !== 16'h0000) begin errors++; $display("FAIL reset_no_bypass got %h want 0000", sr1_data); end
      tick();
      idle_inputs();
      rst = 0;
      #1;
      checks++;
      if (sr1_data !== 16'h0000 || sr1_busy !== 1'b0 || nzp !== 3'b010) begin
         errors++; $display("FAIL reset_discard got %h/%b/%b want 0000/0/010", sr1_data, sr1_busy, nzp);
      end
   endtask

   task automatic test_write_read();
      idle_inputs();
      wr_en = 1; wr_addr = 5; wr_data = 16'hBEEF; sr1_addr = 5; sr2_addr = 0;
      #1;
      checks++;
      if (sr1_data !== 16'hBEEF) begin errors++; $display("FAIL bypass_r5 got %h want BEEF", sr1_data); end
      tick();
      wr_en = 0;
      #1;
      checks++;
      if (sr1_data !== 16'hBEEF) begin errors++; $display("FAIL stored_r5 got %h want BEEF", sr1_data); end
      wr_en = 1; wr_addr = 2; wr_data = 16'd7;
      tick();
      wr_en = 0; sr1_addr = 2; sr2_addr = 2;
      #1;
      checks++;
      if (sr1_data !== 16'd7 || sr2_data !== 16'd7) begin
         errors++; $display("FAIL read_r2 got %h/%h want 0007/0007", sr1_data, sr2_data);
      end
   endtask

   task automatic test_nzp();
      logic [15:0] vals [3];
      logic [2:0]  want [3];
      vals = '{16'h8000, 16'h0000, 16'h0001};
      want = '{3'b100, 3'b010, 3'b001};
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         cc_en = 1; wr_data = vals[i];
         tick();
         cc_en = 0;
         #1;
         checks++;
         if (nzp !== want[i]) begin errors++; $display("FAIL nzp_%h got %b want %b", vals[i], nzp, want[i]); end
      end
      cc_en = 0; wr_data = 16'h0000;
      tick();
      checks++;
      if (nzp !== 3'b001) begin errors++; $display("FAIL nzp_hold got %b want 001", nzp); end
   endtask

   task automatic test_branch();
      logic [2:0] masks [4];
      logic       want  [4];
      masks = '{3'b001, 3'b110, 3'b111, 3'b000};
      want  = '{1'b1, 1'b0, 1'b1, 1'b0};
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         br_nzp = masks[i];
         #1;
         checks++;
         if (br_taken !== want[i]) begin errors++; $display("FAIL br_%b got %b want %b", masks[i], br_taken, want[i]); end
      end
      br_nzp = 3'b001; cc_en = 1; wr_data = 16'h0000;
      #1;
      checks++;
      if (br_taken !== 1'b1) begin errors++; $display("FAIL br_same_cycle got %b want 1", br_taken); end
      tick();
      cc_en = 0;
      #1;
      checks++;
      if (br_taken !== 1'b0) begin errors++; $display("FAIL br_next_cycle got %b want 0", br_taken); end
   endtask

   task automatic test_scoreboard();
      idle_inputs();
      sr1_addr = 4; sr2_addr = 1;
      issue_en = 1; issue_addr = 4;
      #1;
      checks++;
      if (sr1_busy !== 1'b0) begin errors++; $display("FAIL sb_issue_same got %b want 0", sr1_busy); end
      tick();
      issue_en = 0;
      #1;
      checks++;
      if (sr1_busy !== 1'b1) begin errors++; $display("FAIL sb_issue_next got %b want 1", sr1_busy); end
      wr_en = 1; wr_addr = 4; wr_data = 16'h0042;
      #1;
      checks++;
      if (sr1_busy !== 1'b0) begin errors++; $display("FAIL sb_wr_bypass got %b want 0", sr1_busy); end
      tick();
      wr_en = 0;
      #1;
      checks++;
      if (sr1_busy !== 1'b0) begin errors++; $display("FAIL sb_wr_clear got %b want 0", sr1_busy); end
      wr_en = 1; wr_addr = 4; issue_en = 1; issue_addr = 4;
      tick();
      wr_en = 0; issue_en = 0;
      #1;
      checks++;
      if (sr1_busy !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b want 1", sr1_busy); end
      wr_en = 1; wr_addr = 4; issue_en = 1; issue_addr = 1;
      tick();
      wr_en = 0; issue_en = 0;
      #1;
      checks++;
      if (sr1_busy !== 1'b0 || sr2_busy !== 1'b1) begin
         errors++; $display("FAIL sb_diff_regs got %b%b want 01", sr1_busy, sr2_busy);
      end
   endtask

   task automatic test_random();
      logic [15:0] e1, e2;
      logic        b1, b2;
      for (int n = 0; n < 10000; n++) begin
         sr1_addr   = 3'($urandom);
         sr2_addr   = 3'($urandom);
         wr_en      = 1'($urandom);
         wr_addr    = 3'($urandom);
         case ($urandom_range(0, 3))
            0: wr_data = 16'h0000;
            1: wr_data = 16'h8000 | 16'($urandom);
            default: wr_data = 16'($urandom);
         endcase
         cc_en      = 1'($urandom);
         issue_en   = ($urandom_range(0, 2) == 0);
         issue_addr = 3'($urandom);
         br_nzp     = 3'($urandom);
         rst        = ($urandom_range(0, 199) == 0);
         if (rst) model_reset();
         #1;
         e1 = (wr_en && !rst && wr_addr == sr1_addr) ? wr_data : m_reg[sr1_addr];
         e2 = (wr_en && !rst && wr_addr == sr2_addr) ? wr_data : m_reg[sr2_addr];
         b1 = (wr_en && !rst && wr_addr == sr1_addr && !(issue_en && issue_addr == sr1_addr)) ? 1'b0 : m_busy[sr1_addr];
         b2 = (wr_en && !rst && wr_addr == sr2_addr && !(issue_en && issue_addr == sr2_addr)) ? 1'b0 : m_busy[sr2_addr];
         checks++;
         if (sr1_data !== e1) begin errors++; $display("FAIL rnd_sr1_data n=%0d got %h want %h", n, sr1_data, e1); end
         checks++;
         if (sr2_data !== e2) begin errors++; $display("FAIL rnd_sr2_data n=%0d got %h want %h", n, sr2_data, e2); end
         checks++;
         if (sr1_busy !== b1) begin errors++; $display("FAIL rnd_sr1_busy n=%0d got %b want %b", n, sr1_busy, b1); end
         checks++;
         if (sr2_busy !== b2) begin errors++; $display("FAIL rnd_sr2_busy n=%0d got %b want %b", n, sr2_busy, b2); end
         checks++;
         if (nzp !== m_nzp) begin errors++; $display("FAIL rnd_nzp n=%0d got %b want %b", n, nzp, m_nzp); end
         checks++;
         if (br_taken !== ((br_nzp & m_nzp) != 3'b000)) begin
            errors++; $display("FAIL rnd_br_taken n=%0d got %b want %b", n, br_taken, ((br_nzp & m_nzp) != 3'b000));
         end
         tick();
         rst = 0;
      end
   endtask

   initial begin
      rst = 1;
      sr1_addr = 0; sr2_addr = 0;
      idle_inputs();
      model_reset();
      #12;
      rst = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_write_read();
      test_nzp();
      test_branch();
      test_scoreboard();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
